// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 memory responder.
package lc3_mem_pkg;

    localparam int LC3_WORD_W = 16;
    localparam int DEF_RD_LAT = 2;
    localparam int DEF_WR_LAT = 3;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        RD_DONE = 3'd2,
        WR_WAIT = 3'd3,
        WR_DONE = 3'd4,
        ERR     = 3'd5
    } mem_state_t;

endpackage

// File: rtl/lc3_mem_array.sv
// Single-port synchronous word RAM; read data is registered every cycle.
module lc3_mem_array
    import lc3_mem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [LC3_WORD_W-1:0] wdata,
    output logic [LC3_WORD_W-1:0] rdata
);

    logic [LC3_WORD_W-1:0] mem [0:(2**ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/lc3_mem_responder.sv
// LC-3 MAR/MDR memory responder with fixed read/write wait states.
// Optional access counters are enabled by defining LC3_MEM_ACCESS_CNT_EN.
module lc3_mem_responder
    import lc3_mem_pkg::*;
#(
    parameter int ADDR_W = 10,          // 1..15
    parameter int RD_LAT = DEF_RD_LAT,  // 1..7
    parameter int WR_LAT = DEF_WR_LAT   // 1..7
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Mem_OE,
    input  logic                  Mem_WE,
    input  logic [15:0]           ADDR,
    input  logic [LC3_WORD_W-1:0] Data_from_CPU,
    output logic [LC3_WORD_W-1:0] Data_to_CPU,
    output logic                  Mem_Ready,
    output logic                  Proto_Err,
`ifdef LC3_MEM_ACCESS_CNT_EN
    output logic [15:0]           Rd_Count,
    output logic [15:0]           Wr_Count,
`endif
    output mem_state_t            State_Dbg
);

    localparam logic [2:0] RD_LAST = 3'(RD_LAT - 1);
    localparam logic [2:0] WR_LAST = 3'(WR_LAT - 1);

    mem_state_t            state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [ADDR_W-1:0]     addr_q, ram_addr;
    logic [LC3_WORD_W-1:0] data_q, ram_rdata;
    logic                  rdy_q, perr_q;
    logic                  addr_ld, ram_we, data_ld, perr_set;
    logic                  both;
    logic                  unused_addr;

    assign both        = Mem_OE & Mem_WE;
    assign unused_addr = ^ADDR[15:ADDR_W];

    // In IDLE the RAM sees the live address so the first strobe cycle already
    // fetches data; afterwards it sees the latched address.
    assign ram_addr = (state_q == IDLE) ? ADDR[ADDR_W-1:0] : addr_q;

    lc3_mem_array #(.ADDR_W(ADDR_W)) u_array (
        .clk   (Clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (Data_from_CPU),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_ld  = 1'b0;
        ram_we   = 1'b0;
        data_ld  = 1'b0;
        perr_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (both) begin
                    state_d  = ERR;
                    perr_set = 1'b1;
                end else if (Mem_OE) begin
                    addr_ld = 1'b1;
                    cnt_d   = 3'd1;
                    state_d = (RD_LAT == 1) ? RD_DONE : RD_WAIT;
                end else if (Mem_WE) begin
                    addr_ld = 1'b1;
                    cnt_d   = 3'd1;
                    if (WR_LAT == 1) begin
                        ram_we  = 1'b1;
                        state_d = WR_DONE;
                    end else begin
                        state_d = WR_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (both) begin
                    state_d  = ERR;
                    perr_set = 1'b1;
                end else if (!Mem_OE) begin
                    state_d  = IDLE;
                    perr_set = 1'b1;
                end else begin
                    cnt_d = 3'(cnt_q + 3'd1);
                    if (cnt_q == RD_LAST) begin
                        state_d = RD_DONE;
                        data_ld = 1'b1;
                    end
                end
            end
            RD_DONE: begin
                // With single-cycle latency the output register trails the RAM by a cycle.
                data_ld = (RD_LAT == 1);
                if (Mem_WE) begin
                    state_d  = ERR;
                    perr_set = 1'b1;
                end else if (!Mem_OE) begin
                    state_d = IDLE;
                end
            end
            WR_WAIT: begin
                if (both) begin
                    state_d  = ERR;
                    perr_set = 1'b1;
                end else if (!Mem_WE) begin
                    state_d  = IDLE;
                    perr_set = 1'b1;
                end else begin
                    cnt_d = 3'(cnt_q + 3'd1);
                    if (cnt_q == WR_LAST) begin
                        ram_we  = 1'b1;
                        state_d = WR_DONE;
                    end
                end
            end
            WR_DONE: begin
                if (Mem_OE) begin
                    state_d  = ERR;
                    perr_set = 1'b1;
                end else if (!Mem_WE) begin
                    state_d = IDLE;
                end
            end
            ERR: begin
                if (!Mem_OE && !Mem_WE) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            addr_q  <= '0;
            data_q  <= '0;
            rdy_q   <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdy_q   <= (state_d == RD_DONE) || (state_d == WR_DONE);
            if (addr_ld) begin
                addr_q <= ADDR[ADDR_W-1:0];
            end
            if (data_ld) begin
                data_q <= ram_rdata;
            end
            if (perr_set) begin
                perr_q <= 1'b1;
            end
        end
    end

    assign Data_to_CPU = ((RD_LAT == 1) && (state_q == RD_DONE)) ? ram_rdata : data_q;
    assign Mem_Ready   = rdy_q;
    assign Proto_Err   = perr_q;
    assign State_Dbg   = state_q;

`ifdef LC3_MEM_ACCESS_CNT_EN
    logic [15:0] rd_cnt_q, wr_cnt_q;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            rd_cnt_q <= 16'h0000;
            wr_cnt_q <= 16'h0000;
        end else begin
            if ((state_d == RD_DONE) && (state_q != RD_DONE)) begin
                rd_cnt_q <= rd_cnt_q + 16'h0001;
            end
            if (ram_we) begin
                wr_cnt_q <= wr_cnt_q + 16'h0001;
            end
        end
    end

    assign Rd_Count = rd_cnt_q;
    assign Wr_Count = wr_cnt_q;
`endif

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Self-checking bench for lc3_mem_responder with default parameters.
module tb_lc3_mem_responder;
    import lc3_mem_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Mem_OE = 1'b0;
    logic        Mem_WE = 1'b0;
    logic [15:0] ADDR = 16'h0000;
    logic [15:0] Data_from_CPU = 16'h0000;
    logic [15:0] Data_to_CPU;
    logic        Mem_Ready;
    logic        Proto_Err;
    mem_state_t  State_Dbg;
`ifdef LC3_MEM_ACCESS_CNT_EN
    logic [15:0] Rd_Count;
    logic [15:0] Wr_Count;
`endif

    int          n_checks = 0;
    int          n_errors = 0;
    int          exp_rd = 0;
    int          exp_wr = 0;
    logic        exp_perr = 1'b0;
    logic [15:0] exp_q[$];
    logic [15:0] model [0:1023];

    lc3_mem_responder dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .Mem_OE        (Mem_OE),
        .Mem_WE        (Mem_WE),
        .ADDR          (ADDR),
        .Data_from_CPU (Data_from_CPU),
        .Data_to_CPU   (Data_to_CPU),
        .Mem_Ready     (Mem_Ready),
        .Proto_Err     (Proto_Err),
`ifdef LC3_MEM_ACCESS_CNT_EN
        .Rd_Count      (Rd_Count),
        .Wr_Count      (Wr_Count),
`endif
        .State_Dbg     (State_Dbg)
    );

    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Entered and left just after a rising edge with the FSM in IDLE.
    task automatic do_read(input logic [15:0] a);
        logic [15:0] e;
        exp_q.push_back(model[a[9:0]]);
        Mem_OE = 1'b1;
        ADDR   = a;
        @(posedge Clk); #1;
        ADDR = 16'($urandom);
        @(negedge Clk);
        check_eq("rd_ready_early", 16'(Mem_Ready), 16'h0000);
        @(posedge Clk); #1;
        @(negedge Clk);
        check_eq("rd_ready", 16'(Mem_Ready), 16'h0001);
        e = exp_q.pop_front();
        check_eq("rd_data", Data_to_CPU, e);
        @(posedge Clk); #1;
        Mem_OE = 1'b0;
        exp_rd++;
        @(posedge Clk); #1;
        check_eq("rd_ready_drop", 16'(Mem_Ready), 16'h0000);
        check_eq("rd_data_hold", Data_to_CPU, e);
    endtask

    // Address and data are scrambled on non-sampling cycles to prove latching.
    task automatic do_write(input logic [15:0] a, input logic [15:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            Mem_WE        = 1'b1;
            ADDR          = (i == 0) ? a : 16'($urandom);
            Data_from_CPU = (i == n - 1) ? d : 16'($urandom);
            @(posedge Clk); #1;
        end
        Mem_WE        = 1'b0;
        Data_from_CPU = 16'($urandom);
        if (n >= 3) begin
            model[a[9:0]] = d;
            exp_wr++;
            @(negedge Clk);
            check_eq("wr_ready", 16'(Mem_Ready), 16'h0001);
            @(posedge Clk); #1;
            check_eq("wr_ready_drop", 16'(Mem_Ready), 16'h0000);
        end else begin
            exp_perr = 1'b1;
            @(posedge Clk); #1;
            check_eq("short_wr_perr", 16'(Proto_Err), 16'(exp_perr));
            check_eq("short_wr_ready", 16'(Mem_Ready), 16'h0000);
        end
        check_eq("wr_state_idle", 16'(State_Dbg), 16'(IDLE));
    endtask

    initial begin
        logic [15:0] a;
        logic [15:0] d;

        #1;
        check_eq("rst_data", Data_to_CPU, 16'h0000);
        check_eq("rst_ready", 16'(Mem_Ready), 16'h0000);
        check_eq("rst_perr", 16'(Proto_Err), 16'h0000);
        check_eq("rst_state", 16'(State_Dbg), 16'(IDLE));
        repeat (3) @(posedge Clk);
        #1 Reset = 1'b1;
        @(posedge Clk); #1;

        do_write(16'h0040, 16'hBEEF, 3);
        do_read(16'h0040);

        do_write(16'h0400, 16'h1234, 3);
        do_read(16'h0000);

        do_write(16'h0010, 16'h5555, 3);
        do_write(16'h0010, 16'hAAAA, 2);
        do_read(16'h0010);

        // Both strobes together: no write, sticky error, ERR until both drop.
        do_write(16'h0020, 16'h7777, 3);
        Mem_OE        = 1'b1;
        Mem_WE        = 1'b1;
        ADDR          = 16'h0020;
        Data_from_CPU = 16'h0BAD;
        @(posedge Clk); #1;
        check_eq("both_state", 16'(State_Dbg), 16'(ERR));
        check_eq("both_perr", 16'(Proto_Err), 16'h0001);
        check_eq("both_ready", 16'(Mem_Ready), 16'h0000);
        @(posedge Clk); #1;
        Mem_WE = 1'b0;
        @(posedge Clk); #1;
        check_eq("err_hold_state", 16'(State_Dbg), 16'(ERR));
        Mem_OE = 1'b0;
        @(posedge Clk); #1;
        check_eq("err_exit_state", 16'(State_Dbg), 16'(IDLE));
        do_read(16'h0020);

        // Asynchronous reset in the middle of a read.
        Mem_OE = 1'b1;
        ADDR   = 16'h0020;
        @(posedge Clk); #1;
        check_eq("mid_rd_state", 16'(State_Dbg), 16'(RD_WAIT));
        Reset = 1'b0;
        #1;
        check_eq("mid_rst_data", Data_to_CPU, 16'h0000);
        check_eq("mid_rst_ready", 16'(Mem_Ready), 16'h0000);
        check_eq("mid_rst_perr", 16'(Proto_Err), 16'h0000);
        check_eq("mid_rst_state", 16'(State_Dbg), 16'(IDLE));
        Mem_OE = 1'b0;
        @(posedge Clk); #1;
        Reset    = 1'b1;
        exp_perr = 1'b0;
        exp_rd   = 0;
        exp_wr   = 0;
        @(posedge Clk); #1;
        do_read(16'h0020);

        do_write(16'h0010, 16'h9999, 1);
        do_read(16'h0010);

        for (int k = 0; k < 6; k++) begin
            a = 16'($urandom_range(0, 65535));
            d = 16'($urandom);
            do_write(a, d, 3);
            do_read({6'($urandom), a[9:0]});
        end

        check_eq("final_perr", 16'(Proto_Err), 16'(exp_perr));
`ifdef LC3_MEM_ACCESS_CNT_EN
        check_eq("rd_count", Rd_Count, 16'(exp_rd));
        check_eq("wr_count", Wr_Count, 16'(exp_wr));
`endif
        check_eq("sb_empty", 16'(exp_q.size()), 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
